// File: rtl/cu_fsm_ws.sv
// rtl/cu_fsm_ws.sv - multicycle OTTER control-unit FSM with memory wait states and vectored interrupts
module cu_fsm_ws #(
    parameter  int N_IRQ   = 4,
    parameter  int TIMEOUT = 15,
    localparam int ID_W    = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [6:0]       CU_OPCODE,
    input  logic [2:0]       FUNC3,
    input  logic [N_IRQ-1:0] INT,
    input  logic             INT_EN,
    input  logic             MEM_ACK,
    output logic             PC_WRITE,
    output logic             REG_WRITE,
    output logic             MEM_WRITE,
    output logic             MEM_READ1,
    output logic             MEM_READ2,
    output logic             CSR_WRITE,
    output logic             INT_TAKEN,
    output logic [ID_W-1:0]  INT_ID,
    output logic [1:0]       ERR_CODE
);

    localparam int            CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_FTCH, S_EXE, S_MEM, S_WB, S_INTR, S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [N_IRQ-1:0] int_q;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       err_q, err_d;
    logic             store_q, store_d;

    logic             pc_w, reg_w, mem_w, rd1, rd2, csr_w, taken, boundary;
    logic [ID_W-1:0]  irq_id;
    logic [N_IRQ-1:0] irq_clr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_FTCH;
            int_q   <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 2'b00;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            int_q   <= INT;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            store_q <= store_d;
        end
    end

    // Lowest pending index wins: scan downward so the last hit is the lowest.
    always_comb begin
        irq_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pend_q[i]) irq_id = ID_W'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        err_d    = err_q;
        store_d  = store_q;
        irq_clr  = '0;
        boundary = 1'b0;
        pc_w     = 1'b0;
        reg_w    = 1'b0;
        mem_w    = 1'b0;
        rd1      = 1'b0;
        rd2      = 1'b0;
        csr_w    = 1'b0;
        taken    = 1'b0;

        case (state_q)
            S_FTCH: begin
                rd1 = 1'b1;
                if (MEM_ACK) begin
                    state_d = S_EXE;
                end else if (cnt_q == TMO) begin
                    state_d = S_ERR;
                    err_d   = 2'b01;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EXE: begin
                case (CU_OPCODE)
                    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_OP: begin
                        pc_w     = 1'b1;
                        reg_w    = 1'b1;
                        boundary = 1'b1;
                    end
                    OP_BRANCH: begin
                        pc_w     = 1'b1;
                        boundary = 1'b1;
                    end
                    OP_LOAD: begin
                        store_d = 1'b0;
                        state_d = S_MEM;
                    end
                    OP_STORE: begin
                        store_d = 1'b1;
                        state_d = S_MEM;
                    end
                    OP_SYSTEM: begin
                        if (FUNC3 == 3'd4) begin
                            state_d = S_ERR;
                            err_d   = 2'b10;
                        end else begin
                            pc_w     = 1'b1;
                            reg_w    = (FUNC3 != 3'd0);
                            csr_w    = (FUNC3 != 3'd0);
                            boundary = 1'b1;
                        end
                    end
                    default: begin
                        state_d = S_ERR;
                        err_d   = 2'b10;
                    end
                endcase
            end
            S_MEM: begin
                mem_w = store_q;
                rd2   = !store_q;
                if (MEM_ACK) begin
                    if (store_q) begin
                        pc_w     = 1'b1;
                        boundary = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_q == TMO) begin
                    state_d = S_ERR;
                    err_d   = 2'b01;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                pc_w     = 1'b1;
                reg_w    = 1'b1;
                boundary = 1'b1;
            end
            S_INTR: begin
                pc_w            = 1'b1;
                taken           = 1'b1;
                irq_clr[irq_id] = 1'b1;
                state_d         = S_FTCH;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase

        if (boundary) begin
            state_d = (INT_EN && (|pend_q)) ? S_INTR : S_FTCH;
        end

        // A fresh rising edge on the bit being taken re-arms it.
        pend_d = (pend_q & ~irq_clr) | (INT & ~int_q);
    end

    assign PC_WRITE  = pc_w  & ~RST;
    assign REG_WRITE = reg_w & ~RST;
    assign MEM_WRITE = mem_w & ~RST;
    assign MEM_READ1 = rd1   & ~RST;
    assign MEM_READ2 = rd2   & ~RST;
    assign CSR_WRITE = csr_w & ~RST;
    assign INT_TAKEN = taken & ~RST;
    assign INT_ID    = (taken && !RST) ? irq_id : '0;
    assign ERR_CODE  = err_q;

endmodule

// File: tb/tb_cu_fsm_ws.sv
// tb/tb_cu_fsm_ws.sv - scoreboard bench for cu_fsm_ws with an instruction-level reference model
module tb_cu_fsm_ws;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [6:0] CU_OPCODE = 7'd0;
    logic [2:0] FUNC3 = 3'd0;
    logic [3:0] INT = 4'd0;
    logic       INT_EN = 1'b0;
    logic       MEM_ACK = 1'b0;
    logic       PC_WRITE, REG_WRITE, MEM_WRITE, MEM_READ1, MEM_READ2, CSR_WRITE, INT_TAKEN;
    logic [1:0] INT_ID, ERR_CODE;

    cu_fsm_ws #(.N_IRQ(4), .TIMEOUT(15)) dut (
        .CLK(CLK), .RST(RST), .CU_OPCODE(CU_OPCODE), .FUNC3(FUNC3), .INT(INT),
        .INT_EN(INT_EN), .MEM_ACK(MEM_ACK), .PC_WRITE(PC_WRITE), .REG_WRITE(REG_WRITE),
        .MEM_WRITE(MEM_WRITE), .MEM_READ1(MEM_READ1), .MEM_READ2(MEM_READ2),
        .CSR_WRITE(CSR_WRITE), .INT_TAKEN(INT_TAKEN), .INT_ID(INT_ID), .ERR_CODE(ERR_CODE)
    );

    always #5 CLK = ~CLK;

    // {pc, reg, memw, rd1, rd2, csr, taken, id[1:0], err[1:0]}
    typedef logic [10:0] vec_t;
    vec_t        exp_q[$];
    vec_t        act, exp_front;
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b0;
    logic [3:0]  m_pend = 4'd0;
    logic [3:0]  m_int  = 4'd0;

    assign act = {PC_WRITE, REG_WRITE, MEM_WRITE, MEM_READ1, MEM_READ2, CSR_WRITE,
                  INT_TAKEN, INT_ID, ERR_CODE};

    function automatic vec_t mk(input logic pc, input logic rg, input logic mw, input logic r1,
                                input logic r2, input logic cs, input logic tk,
                                input logic [1:0] id, input logic [1:0] err);
        return {pc, rg, mw, r1, r2, cs, tk, id, err};
    endfunction

    always @(negedge CLK) begin
        if (mon_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL monitor: output %b with no expected entry", act);
            end else begin
                exp_front = exp_q.pop_front();
                if (act !== exp_front) begin
                    errors++;
                    $display("FAIL cycle @%0t: got %b want %b (pc rg mw r1 r2 csr tk id err)",
                             $time, act, exp_front);
                end
            end
        end
    end

    task automatic cyc(input vec_t e);
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic take_boundary();
        if (INT_EN && m_pend != 4'd0) begin
            for (int i = 0; i < 4; i++) begin
                if (m_pend[i]) begin
                    cyc(mk(1, 0, 0, 0, 0, 0, 1, 2'(i), 2'b00));
                    m_pend[i] = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input int fw,
                            input int mw, input logic [3:0] ni, input logic en);
        INT    = ni;
        INT_EN = en;
        m_pend = m_pend | (ni & ~m_int);
        m_int  = ni;
        CU_OPCODE = op;
        FUNC3     = f3;
        for (int w = 0; w < fw; w++) begin
            MEM_ACK = 1'b0;
            cyc(mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
        end
        MEM_ACK = 1'b1;
        cyc(mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
        MEM_ACK = 1'($urandom_range(0, 1));
        case (op)
            OP_BRANCH: begin
                cyc(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
            end
            OP_SYSTEM: begin
                if (f3 == 3'd0) cyc(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
                else            cyc(mk(1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00));
            end
            OP_LOAD: begin
                cyc(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
                for (int w = 0; w < mw; w++) begin
                    MEM_ACK = 1'b0;
                    cyc(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
                end
                MEM_ACK = 1'b1;
                cyc(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
                MEM_ACK = 1'($urandom_range(0, 1));
                cyc(mk(1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
            end
            OP_STORE: begin
                cyc(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
                for (int w = 0; w < mw; w++) begin
                    MEM_ACK = 1'b0;
                    cyc(mk(0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00));
                end
                MEM_ACK = 1'b1;
                cyc(mk(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00));
            end
            default: begin
                cyc(mk(1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
            end
        endcase
        take_boundary();
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        INT    = 4'd0;
        RST    = 1'b1;
        #1;
        checks++;
        if (act[10:2] !== 9'd0) begin
            errors++;
            $display("FAIL reset_strobes: got %b want all strobes/id 0", act[10:2]);
        end
        @(posedge CLK);
        @(posedge CLK);
        #1;
        checks++;
        if (act !== 11'd0) begin
            errors++;
            $display("FAIL reset_hold: got %b want 0", act);
        end
        RST     = 1'b0;
        MEM_ACK = 1'b0;
        m_pend  = 4'd0;
        m_int   = 4'd0;
        mon_en  = 1'b1;
    endtask

    logic [6:0] legal_ops [10] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_OP,
                                   OP_BRANCH, OP_LOAD, OP_STORE, OP_SYSTEM};

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        logic [3:0] ni;
        do_reset();

        for (int k = 0; k < 3; k++) do_instr(OP_OP, 3'd0, 0, 0, 4'd0, 1'b1);
        do_instr(OP_LOAD, 3'd2, 0, 3, 4'd0, 1'b1);
        do_instr(OP_STORE, 3'd2, 0, 0, 4'd0, 1'b1);

        do_instr(OP_OP, 3'd0, 0, 0, 4'b1010, 1'b1);
        do_instr(OP_OP, 3'd0, 0, 0, 4'b1010, 1'b1);
        do_instr(OP_OP, 3'd0, 0, 0, 4'b0000, 1'b0);
        do_instr(OP_OP, 3'd0, 0, 0, 4'b0101, 1'b0);
        do_instr(OP_OP, 3'd0, 1, 0, 4'b0101, 1'b0);
        do_instr(OP_SYSTEM, 3'd0, 0, 0, 4'b0101, 1'b1);
        do_instr(OP_SYSTEM, 3'd1, 0, 0, 4'b0101, 1'b1);

        for (int k = 0; k < 80; k++) begin
            op = legal_ops[$urandom_range(0, 9)];
            f3 = 3'($urandom_range(0, 7));
            if (op == OP_SYSTEM && f3 == 3'd4) f3 = 3'd2;
            ni = ($urandom_range(0, 2) == 0) ? 4'($urandom) : m_int;
            do_instr(op, f3, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)),
                     int'($urandom_range(0, 5)), ni, ($urandom_range(0, 3) != 0));
        end

        // Hung fetch: 16 strobed cycles, then sticky bus-timeout error.
        INT_EN  = 1'b1;
        MEM_ACK = 1'b0;
        for (int k = 0; k < 16; k++) cyc(mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
        for (int k = 0; k < 5; k++) begin
            MEM_ACK = 1'($urandom_range(0, 1));
            INT     = 4'($urandom);
            cyc(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01));
        end
        do_reset();

        // Illegal opcode.
        CU_OPCODE = 7'b1111111;
        MEM_ACK   = 1'b1;
        cyc(mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        for (int k = 0; k < 3; k++) cyc(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10));
        do_reset();

        // SYSTEM with funct3==4 is illegal as well.
        CU_OPCODE = OP_SYSTEM;
        FUNC3     = 3'd4;
        MEM_ACK   = 1'b1;
        cyc(mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10));
        do_reset();

        // Reset in the middle of a stalled LOAD data phase.
        CU_OPCODE = OP_LOAD;
        MEM_ACK   = 1'b1;
        cyc(mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        MEM_ACK = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        @(negedge CLK);
        #1;
        do_reset();
        do_instr(OP_JAL, 3'd0, 0, 0, 4'd0, 1'b0);

        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
